// File: rtl/guass_filt_col.sv
// guass_filt_col: vertical pass of the separable 7-tap Gaussian with six line buffers, an internal 3-line flush and a 3-stage arithmetic pipeline.
// Define GUASS_COL_ROUND_EN for round-to-nearest with saturation instead of truncating division.
module guass_filt_col #(
   parameter int          WIDE   = 230,
   parameter int          HIGN   = 235,
   parameter int          DW     = 16,
   parameter int          CNT_DW = 16,
   parameter logic [55:0] KERNEL = 56'h01_0D_2B_3F_2B_0D_01,
   parameter int          SUM    = 177,
   parameter int          R      = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   input  logic [DW-1:0] data_in,
   output logic          ready_out,
   output logic          valid_out,
   output logic [DW-1:0] data_out,
   output logic          frame_done
);

   localparam int SW = DW + 11;
   localparam int AW = (WIDE > 1) ? $clog2(WIDE) : 1;
   localparam logic [CNT_DW-1:0] COL_LAST       = CNT_DW'(WIDE - 1);
   localparam logic [CNT_DW-1:0] ROW_FILL_LAST  = CNT_DW'(2);
   localparam logic [CNT_DW-1:0] ROW_IN_LAST    = CNT_DW'(HIGN - 1);
   localparam logic [CNT_DW-1:0] ROW_FLUSH_LAST = CNT_DW'(HIGN + 2);
   localparam logic [CNT_DW-1:0] ROW_FILT_FIRST = CNT_DW'(6);
   localparam logic [CNT_DW-1:0] ROW_FILT_END   = CNT_DW'(HIGN);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

   state_t            state_reg, state_next;
   logic [CNT_DW-1:0] col_reg, col_next;
   logic [CNT_DW-1:0] row_reg, row_next;
   logic              advance, launch, last_col, last_launch;
   logic [DW-1:0]     pixel;

   assign last_col = (col_reg == COL_LAST);

   always_comb begin
      state_next  = state_reg;
      col_next    = col_reg;
      row_next    = row_reg;
      ready_out   = 1'b1;
      advance     = 1'b0;
      launch      = 1'b0;
      last_launch = 1'b0;
      pixel       = data_in;
      case (state_reg)
         FILL: begin
            advance = valid_in;
            if (valid_in && last_col && row_reg == ROW_FILL_LAST)
               state_next = RUN;
         end
         RUN: begin
            advance = valid_in;
            launch  = valid_in;
            if (valid_in && last_col && row_reg == ROW_IN_LAST)
               state_next = FLUSH;
         end
         FLUSH: begin
            // Lines below the frame are fed as zeros; those rows use the bypass anyway.
            ready_out = 1'b0;
            advance   = 1'b1;
            launch    = 1'b1;
            pixel     = '0;
            if (last_col && row_reg == ROW_FLUSH_LAST) begin
               state_next  = FILL;
               last_launch = 1'b1;
            end
         end
         default: state_next = FILL;
      endcase
      if (advance) begin
         if (last_col) begin
            col_next = '0;
            row_next = last_launch ? '0 : row_reg + 1'b1;
         end else begin
            col_next = col_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= FILL;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   // All six line buffers share one word per column; the read is prefetched for the next column.
   logic [6*DW-1:0] lb_mem [WIDE];
   logic [6*DW-1:0] lb_rd_reg;
   logic [AW-1:0]   rd_addr;

   assign rd_addr = rst ? '0 : col_next[AW-1:0];

   always_ff @(posedge clk) begin
      if (advance && !rst)
         lb_mem[col_reg[AW-1:0]] <= {lb_rd_reg[5*DW-1:0], pixel};
      lb_rd_reg <= lb_mem[rd_addr];
   end

   logic [DW+7:0] tap_w  [R];
   logic [DW+7:0] coef_w [R];
   logic [DW+7:0] prod_reg [R];

   for (genvar gi = 0; gi < R; gi++) begin : g_tap
      if (gi == 0) begin : g_new
         assign tap_w[gi] = {8'd0, pixel};
      end else begin : g_lb
         assign tap_w[gi] = {8'd0, lb_rd_reg[(gi-1)*DW +: DW]};
      end
      assign coef_w[gi] = {{DW{1'b0}}, KERNEL[8*gi +: 8]};
   end

   logic          v1_reg, byp1_reg, last1_reg;
   logic [DW-1:0] ctr1_reg;
   logic          v2_reg, byp2_reg, last2_reg;
   logic [DW-1:0] ctr2_reg;
   logic [SW-1:0] sum2_reg, sum_next;
   logic          byp_now;

   // Centre line c = row-3 is filtered only for 3 <= c <= HIGN-4.
   assign byp_now = (row_reg < ROW_FILT_FIRST) || (row_reg >= ROW_FILT_END);

   always_ff @(posedge clk) begin
      for (int k = 0; k < R; k++)
         prod_reg[k] <= tap_w[k] * coef_w[k];
      ctr1_reg <= lb_rd_reg[2*DW +: DW];
      byp1_reg <= byp_now;
      ctr2_reg <= ctr1_reg;
      byp2_reg <= byp1_reg;
      sum2_reg <= sum_next;
   end

   always_comb begin
      sum_next = '0;
      for (int k = 0; k < R; k++)
         sum_next = sum_next + SW'(prod_reg[k]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg    <= 1'b0;
         last1_reg <= 1'b0;
         v2_reg    <= 1'b0;
         last2_reg <= 1'b0;
      end else begin
         v1_reg    <= launch;
         last1_reg <= last_launch;
         v2_reg    <= v1_reg;
         last2_reg <= last1_reg;
      end
   end

   logic [DW-1:0] filt;
`ifdef GUASS_COL_ROUND_EN
   logic [SW-1:0] rnd_q;
   assign rnd_q = (sum2_reg + SW'(SUM / 2)) / SW'(SUM);
   assign filt  = (rnd_q > {{(SW-DW){1'b0}}, {DW{1'b1}}}) ? {DW{1'b1}} : rnd_q[DW-1:0];
`else
   assign filt = DW'(sum2_reg / SW'(SUM));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out  <= 1'b0;
         data_out   <= '0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= v2_reg;
         frame_done <= v2_reg && last2_reg;
         if (!v2_reg)
            data_out <= '0;
         else if (byp2_reg)
            data_out <= ctr2_reg;
         else
            data_out <= filt;
      end
   end

endmodule

// File: tb/tb_guass_filt_col.sv
// Scoreboard bench for guass_filt_col on an 8x10 frame; expected pixels are queued as stimulus is driven.
module tb_guass_filt_col;
   localparam int WIDE = 8;
   localparam int HIGN = 10;
   localparam int DW   = 16;
   localparam int NPIX = WIDE * HIGN;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          ready_out;
   logic          valid_out;
   logic [DW-1:0] data_out;
   logic          frame_done;

   always #5 clk = ~clk;

   guass_filt_col #(.WIDE(WIDE), .HIGN(HIGN), .DW(DW), .CNT_DW(16)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .ready_out(ready_out), .valid_out(valid_out), .data_out(data_out),
      .frame_done(frame_done)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          done;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   pix [HIGN][WIDE];
   int   out_img [HIGN][WIDE];
   int   out_cnt = 0;
   int   first_out_cyc = 0;
   int   launch30_cyc = 0;
   int   w [7] = '{1, 13, 43, 63, 43, 13, 1};

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops one expectation per output pixel
   always @(posedge clk) begin
      #1;
      if (valid_out === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output got data=%0d done=%b, required no output", data_out, frame_done);
         end else begin
            mon_e = exp_q.pop_front();
            if (data_out !== mon_e.data || frame_done !== mon_e.done) begin
               n_bad++;
               $display("FAIL out_pixel idx=%0d got data=%0d done=%b, required data=%0d done=%b",
                        out_cnt, data_out, frame_done, mon_e.data, mon_e.done);
            end
         end
         if (out_cnt == 0) first_out_cyc = cyc;
         if (out_cnt < NPIX) out_img[out_cnt / WIDE][out_cnt % WIDE] = int'(data_out);
         out_cnt++;
      end else begin
         n_cmp++;
         if (valid_out !== 1'b0 || data_out !== '0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_outputs got valid=%b data=%0d done=%b, required 0/0/0", valid_out, data_out, frame_done);
         end
      end
   end

   function automatic int model(input int r, input int c);
      int s;
      if (r < 3 || r > HIGN - 4) return pix[r][c];
      s = 0;
      for (int k = 0; k < 7; k++) s += w[k] * pix[r + 3 - k][c];
`ifdef GUASS_COL_ROUND_EN
      s = (s + 88) / 177;
      if (s > 65535) s = 65535;
`else
      s = s / 177;
`endif
      return s;
   endfunction

   task automatic push_exp(input int r, input int c);
      exp_t t;
      t.data = DW'(model(r, c));
      t.done = (r == HIGN - 1 && c == WIDE - 1);
      exp_q.push_back(t);
   endtask

   task automatic send_pixel(input int r, input int c, input bit gap);
      int guard;
      guard = 0;
      if (gap) @(negedge clk);
      while (ready_out !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (ready_out !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout got ready=%b, required 1 at pixel (%0d,%0d)", ready_out, r, c);
      end
      valid_in = 1'b1;
      data_in  = DW'(pix[r][c]);
      if (r == 3 && c == 0) launch30_cyc = cyc;
      if (r >= 3) push_exp(r - 3, c);
      if (r == HIGN - 1 && c == WIDE - 1)
         for (int rr = HIGN - 3; rr < HIGN; rr++)
            for (int cc = 0; cc < WIDE; cc++) push_exp(rr, cc);
      @(negedge clk);
      valid_in = 1'b0;
      data_in  = '0;
   endtask

   task automatic drain_frame(input int pre_low);
      int lowc;
      int guard;
      lowc  = pre_low;
      guard = 0;
      while (ready_out === 1'b0 && guard < 200) begin
         lowc++;
         guard++;
         @(negedge clk);
      end
      n_cmp++;
      if (lowc != 3 * WIDE) begin
         n_bad++;
         $display("FAIL flush_length got %0d ready-low cycles, required %0d", lowc, 3 * WIDE);
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout got %0d pending outputs, required 0", exp_q.size());
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (out_cnt != NPIX) begin
         n_bad++;
         $display("FAIL out_count got %0d, required %0d", out_cnt, NPIX);
      end
   endtask

   task automatic run_frame(input bit gap, input bit pulses);
      int pre;
      pre     = 0;
      out_cnt = 0;
      for (int r = 0; r < HIGN; r++)
         for (int c = 0; c < WIDE; c++) send_pixel(r, c, gap);
      if (pulses) begin
         for (int i = 0; i < 10; i++) begin
            valid_in = (i % 2 == 0);
            data_in  = DW'(5000);
            n_cmp++;
            if (ready_out !== 1'b0) begin
               n_bad++;
               $display("FAIL flush_ready got %b, required 0 (flush cycle %0d)", ready_out, i);
            end
            @(negedge clk);
         end
         valid_in = 1'b0;
         data_in  = '0;
         pre      = 10;
      end
      drain_frame(pre);
   endtask

   task automatic fill_const(input int v);
      for (int r = 0; r < HIGN; r++)
         for (int c = 0; c < WIDE; c++) pix[r][c] = v;
   endtask

   task automatic check_reset_state(input string tag);
      n_cmp++;
      if (valid_out !== 1'b0 || data_out !== '0 || ready_out !== 1'b1 || frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s got valid=%b data=%0d ready=%b done=%b, required 0/0/1/0",
                  tag, valid_out, data_out, ready_out, frame_done);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      valid_in = 1'b0;
      data_in = '0;
      repeat (2) @(negedge clk);
      check_reset_state("reset_init");
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("after_reset");
   endtask

   task automatic test_constant;
      fill_const(100);
      run_frame(1'b0, 1'b0);
      n_cmp++;
      if (first_out_cyc - launch30_cyc != 3) begin
         n_bad++;
         $display("FAIL first_latency got %0d cycles, required 3", first_out_cyc - launch30_cyc);
      end
      n_cmp++;
      if (out_img[HIGN/2][WIDE/2] != 100) begin
         n_bad++;
         $display("FAIL const_centre got %0d, required 100", out_img[HIGN/2][WIDE/2]);
      end
   endtask

   task automatic test_impulse;
      int want [8] = '{0, 0, 0, 13, 43, 63, 43, 0};
      fill_const(0);
      pix[5][2] = 177;
      run_frame(1'b0, 1'b0);
      for (int r = 0; r < 8; r++) begin
         n_cmp++;
         if (out_img[r][2] != want[r]) begin
            n_bad++;
            $display("FAIL impulse_col2 row=%0d got %0d, required %0d", r, out_img[r][2], want[r]);
         end
      end
   endtask

   task automatic test_border;
      for (int r = 0; r < HIGN; r++)
         for (int c = 0; c < WIDE; c++) pix[r][c] = 1000 + r;
      run_frame(1'b0, 1'b0);
      for (int r = 0; r < HIGN; r++) begin
         n_cmp++;
         // A symmetric kernel on a linear ramp reproduces the centre line exactly.
         if (out_img[r][0] != 1000 + r) begin
            n_bad++;
            $display("FAIL border_row row=%0d got %0d, required %0d", r, out_img[r][0], 1000 + r);
         end
      end
   endtask

   task automatic test_gappy;
      fill_const(100);
      run_frame(1'b1, 1'b1);
      n_cmp++;
      if (out_img[HIGN-1][WIDE-1] != 100) begin
         n_bad++;
         $display("FAIL gappy_last got %0d, required 100", out_img[HIGN-1][WIDE-1]);
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < HIGN; r++)
         for (int c = 0; c < WIDE; c++) pix[r][c] = int'($urandom_range(0, 65535));
      run_frame(1'b0, 1'b0);
   endtask

   task automatic test_saturate;
      fill_const(65535);
      run_frame(1'b0, 1'b0);
      n_cmp++;
      if (out_img[4][3] != 65535) begin
         n_bad++;
         $display("FAIL saturate got %0d, required 65535", out_img[4][3]);
      end
   endtask

   task automatic test_reset_midrun;
      fill_const(250);
      out_cnt = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < WIDE; c++) send_pixel(r, c, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset_state("reset_mid_1");
      @(negedge clk);
      check_reset_state("reset_mid_2");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      fill_const(77);
      run_frame(1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no finish, required completion before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_constant();
      test_impulse();
      test_border();
      test_gappy();
      test_random();
      test_saturate();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
